// File: rtl/k_fifo_pkg.sv
// Shared FIFO definitions: default geometry and the binary-to-Gray helper
// used by both pointer domains.
package k_fifo_pkg;

    localparam int K_FIFO_ADDR_SIZE  = 4;
    localparam int K_FIFO_AEMPTY_LVL = 2;

    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/k_gray2bin.sv
// Combinational Gray-to-binary converter of width W: each binary bit is the
// XOR of all Gray bits at and above its position.
module k_gray2bin #(
    parameter int W = 5
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    for (genvar gi = 0; gi < W; gi++) begin : g_bit
        assign bin[gi] = ^gray[W-1:gi];
    end

endmodule

// File: rtl/k_rctl_gray.sv
// Read-side pointer and flag control for an async FIFO with Gray pointers.
// Define K_RCTL_UNDERFLOW_EN to add the sticky runderflow output.
module k_rctl_gray
    import k_fifo_pkg::*;
#(
    parameter int ADDR_SIZE  = K_FIFO_ADDR_SIZE,
    parameter int AEMPTY_LVL = K_FIFO_AEMPTY_LVL
) (
    input  logic                 rclk,
    input  logic                 rrst_n,
    input  logic                 rget,
    input  logic [ADDR_SIZE:0]   rq2_wptr,
    output logic [ADDR_SIZE-1:0] raddr,
    output logic [ADDR_SIZE:0]   rptr,
    output logic                 rempty,
    output logic                 raempty,
    output logic [ADDR_SIZE:0]   rcount
`ifdef K_RCTL_UNDERFLOW_EN
    ,
    output logic                 runderflow
`endif
);

    localparam int PTR_W = ADDR_SIZE + 1;
    localparam logic [PTR_W-1:0] AEMPTY_V = PTR_W'(AEMPTY_LVL);

    logic [PTR_W-1:0] rbin_q,   rbin_d;
    logic [PTR_W-1:0] rptr_q,   rptr_d;
    logic [PTR_W-1:0] rcount_q, rcount_d;
    logic             rempty_q, rempty_d;
    logic             raempty_q, raempty_d;
    logic [PTR_W-1:0] wbin;
    logic [PTR_W-1:0] occ;
    logic             ren;

    k_gray2bin #(
        .W(PTR_W)
    ) u_wptr_g2b (
        .gray(rq2_wptr),
        .bin (wbin)
    );

    // Flags are computed from the post-read pointer against this cycle's
    // write pointer so a read racing a write never yields a stale empty.
    always_comb begin
        ren       = rget & ~rempty_q;
        rbin_d    = rbin_q + {{ADDR_SIZE{1'b0}}, ren};
        rptr_d    = PTR_W'(bin2gray(32'(rbin_d)));
        occ       = wbin - rbin_d;
        rcount_d  = occ;
        rempty_d  = (rptr_d == rq2_wptr);
        raempty_d = (occ <= AEMPTY_V);
    end

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            rbin_q    <= '0;
            rptr_q    <= '0;
            rcount_q  <= '0;
            rempty_q  <= 1'b1;
            raempty_q <= 1'b1;
        end else begin
            rbin_q    <= rbin_d;
            rptr_q    <= rptr_d;
            rcount_q  <= rcount_d;
            rempty_q  <= rempty_d;
            raempty_q <= raempty_d;
        end
    end

`ifdef K_RCTL_UNDERFLOW_EN
    logic runderflow_q, runderflow_d;

    always_comb begin
        runderflow_d = runderflow_q | (rget & rempty_q);
    end

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            runderflow_q <= 1'b0;
        end else begin
            runderflow_q <= runderflow_d;
        end
    end

    assign runderflow = runderflow_q;
`endif

    assign raddr   = rbin_q[ADDR_SIZE-1:0];
    assign rptr    = rptr_q;
    assign rempty  = rempty_q;
    assign raempty = raempty_q;
    assign rcount  = rcount_q;

endmodule

// File: tb/tb_k_rctl_gray.sv
// Randomised self-checking bench for k_rctl_gray against a counter-based
// occupancy model (ADDR_SIZE=4, AEMPTY_LVL=2).
module tb_k_rctl_gray;

    logic       rclk = 1'b0;
    logic       rrst_n = 1'b0;
    logic       rget = 1'b0;
    logic [4:0] rq2_wptr = '0;
    logic [3:0] raddr;
    logic [4:0] rptr;
    logic       rempty;
    logic       raempty;
    logic [4:0] rcount;
`ifdef K_RCTL_UNDERFLOW_EN
    logic       runderflow;
    bit         m_uf;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    // Model: plain integer read/write counts modulo 32.
    int m_rd = 0;
    int m_wr = 0;
    int m_count = 0;
    bit m_empty = 1;
    bit m_aempty = 1;

    k_rctl_gray #(
        .ADDR_SIZE (4),
        .AEMPTY_LVL(2)
    ) dut (
        .rclk    (rclk),
        .rrst_n  (rrst_n),
        .rget    (rget),
        .rq2_wptr(rq2_wptr),
        .raddr   (raddr),
        .rptr    (rptr),
        .rempty  (rempty),
        .raempty (raempty),
        .rcount  (rcount)
`ifdef K_RCTL_UNDERFLOW_EN
        ,
        .runderflow(runderflow)
`endif
    );

    always #5 rclk = ~rclk;

    function automatic logic [4:0] g(input int v);
        logic [4:0] b;
        b = v[4:0];
        return b ^ (b >> 1);
    endfunction

    task automatic step(input logic get, input logic rst_n);
        rget     = get;
        rrst_n   = rst_n;
        rq2_wptr = g(m_wr);
        @(posedge rclk);
        if (!rst_n) begin
            m_rd = 0; m_count = 0; m_empty = 1; m_aempty = 1;
`ifdef K_RCTL_UNDERFLOW_EN
            m_uf = 0;
`endif
        end else begin
`ifdef K_RCTL_UNDERFLOW_EN
            if (get && m_empty) m_uf = 1;
`endif
            if (get && !m_empty) m_rd = (m_rd + 1) % 32;
            m_count  = (m_wr - m_rd + 32) % 32;
            m_empty  = (m_count == 0);
            m_aempty = (m_count <= 2);
        end
        #1;
    endtask

    task automatic test_reset;
        m_wr = 2;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        n_chk++; if (rptr !== 5'd0) $display("FAIL reset_rptr got %b exp 00000", rptr); else n_pass++;
        n_chk++; if (raddr !== 4'd0) $display("FAIL reset_raddr got %0d exp 0", raddr); else n_pass++;
        n_chk++; if (rempty !== 1'b1) $display("FAIL reset_rempty got %b exp 1", rempty); else n_pass++;
        n_chk++; if (raempty !== 1'b1) $display("FAIL reset_raempty got %b exp 1", raempty); else n_pass++;
        n_chk++; if (rcount !== 5'd0) $display("FAIL reset_rcount got %0d exp 0", rcount); else n_pass++;
        step(1'b1, 1'b1);
        n_chk++; if (rcount !== 5'(m_count)) $display("FAIL release_rcount got %0d exp %0d", rcount, m_count); else n_pass++;
        n_chk++; if (rempty !== m_empty) $display("FAIL release_rempty got %b exp %b", rempty, m_empty); else n_pass++;
    endtask

    task automatic test_read_seq;
        m_wr = 3;
        step(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1);
            n_chk++; if (raddr !== 4'(m_rd)) $display("FAIL seq_raddr[%0d] got %0d exp %0d", i, raddr, m_rd % 16); else n_pass++;
            n_chk++; if (rempty !== m_empty) $display("FAIL seq_rempty[%0d] got %b exp %b", i, rempty, m_empty); else n_pass++;
        end
        n_chk++; if (rptr !== 5'b00010) $display("FAIL seq_rptr got %b exp 00010", rptr); else n_pass++;
    endtask

    task automatic test_wrap;
        int guard;
        m_wr = 20;
        guard = 0;
        while (m_rd != 16 && guard < 40) begin
            step(1'b1, 1'b1);
            guard++;
        end
        n_chk++; if (m_rd != 16) $display("FAIL wrap_timeout got rd %0d exp 16", m_rd); else n_pass++;
        n_chk++; if (rptr !== 5'b11000) $display("FAIL wrap_rptr got %b exp 11000", rptr); else n_pass++;
        n_chk++; if (raddr !== 4'd0) $display("FAIL wrap_raddr got %0d exp 0", raddr); else n_pass++;
        n_chk++; if (rcount !== 5'd4) $display("FAIL wrap_rcount got %0d exp 4", rcount); else n_pass++;
        n_chk++; if (rempty !== 1'b0) $display("FAIL wrap_rempty got %b exp 0", rempty); else n_pass++;
    endtask

    task automatic test_aempty;
        m_wr = 5;
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        n_chk++; if (rcount !== 5'd5) $display("FAIL aempty_start got %0d exp 5", rcount); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1);
            n_chk++; if (rcount !== 5'(m_count)) $display("FAIL aempty_rcount[%0d] got %0d exp %0d", i, rcount, m_count); else n_pass++;
            n_chk++; if (raempty !== m_aempty) $display("FAIL aempty_flag[%0d] got %b exp %b", i, raempty, m_aempty); else n_pass++;
            n_chk++; if (rempty !== m_empty) $display("FAIL aempty_empty[%0d] got %b exp %b", i, rempty, m_empty); else n_pass++;
        end
    endtask

    task automatic test_mid_reset;
        step(1'b0, 1'b0);
        m_wr = 10;
        step(1'b0, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1);
        n_chk++; if (raddr !== 4'd7) $display("FAIL midrst_pre got %0d exp 7", raddr); else n_pass++;
        step(1'b1, 1'b0);
        n_chk++; if (rptr !== 5'd0) $display("FAIL midrst_rptr got %b exp 00000", rptr); else n_pass++;
        n_chk++; if (raddr !== 4'd0) $display("FAIL midrst_raddr got %0d exp 0", raddr); else n_pass++;
        n_chk++; if (rempty !== 1'b1) $display("FAIL midrst_rempty got %b exp 1", rempty); else n_pass++;
        n_chk++; if (rcount !== 5'd0) $display("FAIL midrst_rcount got %0d exp 0", rcount); else n_pass++;
        step(1'b0, 1'b1);
    endtask

    task automatic test_random;
        int nxt;
        for (int i = 0; i < 300; i++) begin
            nxt = (m_wr + int'($urandom_range(0, 2))) % 32;
            if ((nxt - m_rd + 32) % 32 <= 16) m_wr = nxt;
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 60) != 0));
            n_chk++; if (rptr !== g(m_rd)) $display("FAIL rnd_rptr[%0d] got %b exp %b", i, rptr, g(m_rd)); else n_pass++;
            n_chk++; if (raddr !== 4'(m_rd)) $display("FAIL rnd_raddr[%0d] got %0d exp %0d", i, raddr, m_rd % 16); else n_pass++;
            n_chk++; if (rcount !== 5'(m_count)) $display("FAIL rnd_rcount[%0d] got %0d exp %0d", i, rcount, m_count); else n_pass++;
            n_chk++; if (rempty !== m_empty) $display("FAIL rnd_rempty[%0d] got %b exp %b", i, rempty, m_empty); else n_pass++;
            n_chk++; if (raempty !== m_aempty) $display("FAIL rnd_raempty[%0d] got %b exp %b", i, raempty, m_aempty); else n_pass++;
`ifdef K_RCTL_UNDERFLOW_EN
            n_chk++; if (runderflow !== m_uf) $display("FAIL rnd_uf[%0d] got %b exp %b", i, runderflow, m_uf); else n_pass++;
`endif
        end
    endtask

`ifdef K_RCTL_UNDERFLOW_EN
    task automatic test_underflow;
        step(1'b0, 1'b0);
        m_wr = 0;
        step(1'b0, 1'b1);
        n_chk++; if (runderflow !== 1'b0) $display("FAIL uf_clear got %b exp 0", runderflow); else n_pass++;
        step(1'b1, 1'b1);
        n_chk++; if (runderflow !== 1'b1) $display("FAIL uf_set got %b exp 1", runderflow); else n_pass++;
        m_wr = 3;
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        n_chk++; if (runderflow !== 1'b1) $display("FAIL uf_sticky got %b exp 1", runderflow); else n_pass++;
        step(1'b0, 1'b0);
        n_chk++; if (runderflow !== 1'b0) $display("FAIL uf_reset got %b exp 0", runderflow); else n_pass++;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge rclk);
        test_reset();
        test_read_seq();
        test_wrap();
        test_aempty();
        test_mid_reset();
`ifdef K_RCTL_UNDERFLOW_EN
        test_underflow();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
